multiplier_unsigned_seq: RTL and testbench

Sequential radix-2 shift-add unsigned multiplier. It is the inverse datapath companion to the combinational unsigned divider in the same arithmetic lab set. It takes two WIDTH-bit unsigned operands and produces a 2*WIDTH-bit product over WIDTH iterations, using a start/busy/done handshake. It is intended as the multi-cycle MUL unit beside the divider in the lab ALU.

---
 rtl/multiplier_unsigned_seq.sv | 82 ++++++++
 tb/tb_multiplier_unsigned_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/multiplier_unsigned_seq.sv
// Radix-2 shift-add unsigned multiplier: WIDTH x WIDTH -> 2*WIDTH product over WIDTH clocks.
// Uses a start/busy/done handshake and accepts back-to-back requests in the DONE cycle.
module multiplier_unsigned_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_count;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_accNext;
  logic               w_lastIter;
  logic               w_accept;

  // One iteration: add A into the upper half, then shift {carry, acc} right by one.
  always_comb begin
    w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_b[0] ? {1'b0, r_a} : '0);
    w_accNext  = {w_sum, r_acc[WIDTH-1:1]};
    w_lastIter = (r_count == CW'(WIDTH - 1));
    w_accept   = start && (r_state != CALC);
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = CALC;
      CALC:    if (w_lastIter) w_nextState = DONE;
      DONE:    w_nextState = start ? CALC : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_nextState;
      busy    <= (w_nextState == CALC);
      done    <= (w_nextState == DONE);
    end
  end

  // product is written only on the final iteration, so it holds through IDLE and the next CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_count <= '0;
      product <= '0;
    end else if (w_accept) begin
      r_a     <= multiplicand;
      r_b     <= multiplier;
      r_acc   <= '0;
      r_count <= '0;
    end else if (r_state == CALC) begin
      r_acc   <= w_accNext;
      r_b     <= r_b >> 1;
      r_count <= r_count + CW'(1);
      if (w_lastIter) product <= w_accNext;
    end
  end

endmodule

// File: tb/tb_multiplier_unsigned_seq.sv
// Scoreboard bench for multiplier_unsigned_seq: stimulus pushes expected product and done edge,
// per-instance monitors pop and compare whenever done is seen.
module tb_multiplier_unsigned_seq;

  typedef struct {
    logic [63:0] prod;
    int          edgeNo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start32 = 1'b0;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;
  logic        busy32;
  logic        done32;
  logic [63:0] product32;
  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy8;
  logic        done8;
  logic [15:0] product8;

  int   cycle = 0;
  int   checkCount = 0;
  int   passCount = 0;
  exp_t q32[$];
  exp_t q8[$];
  exp_t e32;
  exp_t e8;

  multiplier_unsigned_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32),
    .multiplicand(a32), .multiplier(b32),
    .busy(busy32), .done(done32), .product(product32)
  );

  multiplier_unsigned_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .multiplicand(a8), .multiplier(b8),
    .busy(busy8), .done(done8), .product(product8)
  );

  always #5 clk = ~clk;

  // Edge counter; read at negedges so it equals the number of rising edges so far.
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Issues one request from a negedge; optionally records the expected result and done edge.
  task automatic applyStimulus(input bit wide8, input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] expProd, input bit expectDone);
    exp_t e;
    @(negedge clk);
    e.prod = expProd;
    if (wide8) begin
      start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0];
      e.edgeNo = cycle + 1 + 8;
      if (expectDone) q8.push_back(e);
    end else begin
      start32 = 1'b1; a32 = a; b32 = b;
      e.edgeNo = cycle + 1 + 32;
      if (expectDone) q32.push_back(e);
    end
    @(negedge clk);
    start8 = 1'b0; start32 = 1'b0;
    a32 = ~a; b32 = b ^ 32'h5A5A_A5A5;
    a8 = ~a[7:0]; b8 = ~b[7:0];
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (q32.size() == 0 && q8.size() == 0) break;
      @(negedge clk);
    end
    #1;
    checkOutput("queueDrained", 64'(q32.size() + q8.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && done32) begin
      if (q32.size() == 0) begin
        checkOutput("unexpectedDone32", 64'd1, 64'd0);
      end else begin
        e32 = q32.pop_front();
        checkOutput("product32", product32, e32.prod);
        checkOutput("doneEdge32", 64'(cycle), 64'(e32.edgeNo));
        checkOutput("busyInDone32", 64'(busy32), 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        checkOutput("unexpectedDone8", 64'd1, 64'd0);
      end else begin
        e8 = q8.pop_front();
        checkOutput("product8", 64'(product8), e8.prod);
        checkOutput("doneEdge8", 64'(cycle), 64'(e8.edgeNo));
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    checkOutput("resetBusy", 64'(busy32), 64'd0);
    checkOutput("resetDone", 64'(done32), 64'd0);
    checkOutput("resetProduct", product32, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic 7*6 with busy-duration count
    applyStimulus(1'b0, 32'd7, 32'd6, 64'd42, 1'b1);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (done32) break;
      if (busy32) n++;
      @(negedge clk);
    end
    checkOutput("busyCycles", 64'(n), 64'd32);
    drain();

    // Boundary and general operands
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
    drain();
    applyStimulus(1'b0, 32'd123456789, 32'd987, 64'd121851850743, 1'b1);
    drain();
    applyStimulus(1'b0, 32'd0, 32'd50, 64'd0, 1'b1);
    drain();
    applyStimulus(1'b0, 32'h8000_0000, 32'd2, 64'h1_0000_0000, 1'b1);
    drain();

    // start while busy must be ignored
    applyStimulus(1'b0, 32'd100, 32'd7, 64'd700, 1'b1);
    repeat (9) @(negedge clk);
    start32 = 1'b1; a32 = 32'd3; b32 = 32'd3;
    @(negedge clk);
    start32 = 1'b0; a32 = 32'd11; b32 = 32'd13;
    drain();
    repeat (40) @(negedge clk);

    // Back-to-back with start held high
    @(negedge clk);
    start32 = 1'b1; a32 = 32'd5; b32 = 32'd5;
    e32.prod = 64'd25; e32.edgeNo = cycle + 33;
    q32.push_back(e32);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done32) break;
    end
    a32 = 32'd9; b32 = 32'd9;
    e32.prod = 64'd81; e32.edgeNo = cycle + 33;
    q32.push_back(e32);
    @(negedge clk);
    start32 = 1'b0; a32 = 32'd0; b32 = 32'd0;
    checkOutput("b2bNoGapBusy", 64'(busy32), 64'd1);
    checkOutput("holdProductEarly", product32, 64'd25);
    repeat (10) @(negedge clk);
    checkOutput("holdProductMid", product32, 64'd25);
    drain();

    // Asynchronous reset mid-operation
    applyStimulus(1'b0, 32'd1024, 32'd1025, 64'd0, 1'b0);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abortBusy", 64'(busy32), 64'd0);
    checkOutput("abortDone", 64'(done32), 64'd0);
    checkOutput("abortProduct", product32, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    applyStimulus(1'b0, 32'd2, 32'd4, 64'd8, 1'b1);
    drain();

    // Narrow instance
    applyStimulus(1'b1, 32'hFF, 32'hFF, 64'hFE01, 1'b1);
    drain();
    applyStimulus(1'b1, 32'hFF, 32'h01, 64'h00FF, 1'b1);
    drain();

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
